// File: rtl/rom_loader.sv
// rom_loader: HPS ioctl bytes -> DEPTH-entry FIFO -> port1/port2 SDRAM toggle handshakes and/or BRAM strobe; ROM_LOADER_CHECKSUM_EN adds a byte checksum.
// Push 1 clk after ioctl_wr rise, head delivered 1 clk after push; head stalls on a busy port, ioctl_wait throttles the HPS at DEPTH-2.
module rom_loader #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        dl_wr,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded,
    output logic        overflow
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_HI   = (AW+1)'(DEPTH - 2);

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } ent_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    ent_t        r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    state_t      r_state;
    state_t      w_next;

    logic        r_wr_d;
    logic        r_dl_d;
    logic        r_fall_pend;
    logic        r_rom_loaded;
    logic        r_overflow;

    logic        r_p1_req;
    logic [22:0] r_p1_a;
    logic [1:0]  r_p1_ds;
    logic [15:0] r_p1_d;
    logic        r_p2_req;
    logic [22:0] r_p2_a;
    logic [1:0]  r_p2_ds;
    logic [15:0] r_p2_d;
    logic        r_dl_wr;
    logic [16:0] r_dl_addr;
    logic [7:0]  r_dl_data;

    logic        w_wr_rise;
    logic        w_push_try;
    logic        w_push;
    logic        w_ovf;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic        w_dl_rise;
    logic        w_dl_fall;
    ent_t        w_head;
    logic [23:0] w_off;
    logic        w_tgt_p1;
    logic        w_tgt_p2;
    logic        w_tgt_br;
    logic        w_discard;
    logic        w_p1_idle;
    logic        w_p2_idle;
    logic        w_ports_ok;
    logic        w_drained;
    logic        w_go_p1;
    logic        w_go_p2;
    logic        w_go_br;

    assign w_wr_rise  = ioctl_wr & ~r_wr_d;
    assign w_push_try = w_wr_rise & ioctl_download & (ioctl_index == 8'd0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_FULL);
    // A full FIFO still accepts a byte when the head pops in the same cycle.
    assign w_push     = w_push_try & (~w_full | w_pop);
    assign w_ovf      = w_push_try & w_full & ~w_pop;
    assign w_dl_rise  = ioctl_download & ~r_dl_d;
    assign w_dl_fall  = ~ioctl_download & r_dl_d;

    assign w_head     = r_mem[r_rptr];
    assign w_off      = w_head.addr[23:0] - 24'h010000;
    assign w_tgt_p1   = (w_head.addr < 25'h0010000);
    assign w_tgt_p2   = (w_head.addr >= 25'h0010000) && (w_head.addr < 25'h001C000);
    assign w_tgt_br   = ((w_head.addr >= 25'h000A000) && (w_head.addr < 25'h0010000)) ||
                        ((w_head.addr >= 25'h001C000) && (w_head.addr < 25'h0020000));
    assign w_discard  = (w_head.addr >= 25'h0020000);

    assign w_p1_idle  = (r_p1_req == port1_ack);
    assign w_p2_idle  = (r_p2_req == port2_ack);
    assign w_ports_ok = (~w_tgt_p1 | w_p1_idle) & (~w_tgt_p2 | w_p2_idle);
    assign w_drained  = w_empty & (r_state == S_IDLE) & w_p1_idle & w_p2_idle;

    // Delivery is registered on the IDLE->ISSUE edge, so ISSUE is the cycle the strobes are visible.
    always_comb begin
        w_next  = r_state;
        w_go_p1 = 1'b0;
        w_go_p2 = 1'b0;
        w_go_br = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_discard) begin
                        w_pop = 1'b1;
                    end else if (w_ports_ok) begin
                        w_go_p1 = w_tgt_p1;
                        w_go_p2 = w_tgt_p2;
                        w_go_br = w_tgt_br;
                        w_next  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_tgt_p1 || w_tgt_p2) begin
                    w_next = S_WAIT;
                end else begin
                    w_pop  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_ports_ok) begin
                    w_pop  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {ioctl_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_d  <= 1'b0;
            r_dl_d  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wr_d <= ioctl_wr;
            r_dl_d <= ioctl_download;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_req  <= 1'b0;
            r_p1_a    <= '0;
            r_p1_ds   <= '0;
            r_p1_d    <= '0;
            r_p2_req  <= 1'b0;
            r_p2_a    <= '0;
            r_p2_ds   <= '0;
            r_p2_d    <= '0;
            r_dl_wr   <= 1'b0;
            r_dl_addr <= '0;
            r_dl_data <= '0;
        end else begin
            r_dl_wr <= w_go_br;
            if (w_go_br) begin
                r_dl_addr <= w_head.addr[16:0];
                r_dl_data <= w_head.data;
            end
            if (w_go_p1) begin
                r_p1_a   <= w_head.addr[23:1];
                r_p1_ds  <= {w_head.addr[0], ~w_head.addr[0]};
                r_p1_d   <= {w_head.data, w_head.data};
                r_p1_req <= ~r_p1_req;
            end
            // Sprite words: bit 15 of the offset selects the 16-bit half, bit 14 the byte lane.
            if (w_go_p2) begin
                r_p2_a   <= {w_off[23:16], w_off[13:0], w_off[15]};
                r_p2_ds  <= {w_off[14], ~w_off[14]};
                r_p2_d   <= {w_head.data, w_head.data};
                r_p2_req <= ~r_p2_req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fall_pend  <= 1'b0;
            r_rom_loaded <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= (r_overflow & ~w_dl_rise) | w_ovf;
            if (w_dl_rise) begin
                r_rom_loaded <= 1'b0;
                r_fall_pend  <= 1'b0;
            end else if (w_dl_fall) begin
                r_fall_pend <= 1'b1;
            end else if (r_fall_pend && w_drained) begin
                r_rom_loaded <= 1'b1;
                r_fall_pend  <= 1'b0;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;
    logic [15:0] w_cs_base;

    assign w_cs_base = w_dl_rise ? 16'd0 : r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= 16'd0;
        end else begin
            r_checksum <= w_push ? (w_cs_base + {8'd0, ioctl_dout}) : w_cs_base;
        end
    end

    assign checksum = r_checksum;
`else
    // Without the checksum build there is no adder and no checksum port.
`endif

    assign ioctl_wait = (r_count >= C_HI) | r_fall_pend;
    assign port1_req  = r_p1_req;
    assign port1_a    = r_p1_a;
    assign port1_ds   = r_p1_ds;
    assign port1_d    = r_p1_d;
    assign port2_req  = r_p2_req;
    assign port2_a    = r_p2_a;
    assign port2_ds   = r_p2_ds;
    assign port2_d    = r_p2_d;
    assign dl_wr      = r_dl_wr;
    assign dl_addr    = r_dl_addr;
    assign dl_data    = r_dl_data;
    assign rom_loaded = r_rom_loaded;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: routing vector table plus backpressure, overflow, completion and reset sequences.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        rom_loaded;
    logic        overflow;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    rom_loader #(.DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .rom_loaded(rom_loaded), .overflow(overflow)
`ifdef ROM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [22:0] a; logic [1:0] ds; logic [15:0] d; } preq_t;
    typedef struct { logic [16:0] a; logic [7:0] d; } bw_t;
    typedef struct {
        logic [24:0] a; logic [7:0] d; logic [7:0] idx;
        int n1; int n2; int nb; logic [22:0] pa; logic [1:0] ds;
    } vec_t;

    preq_t q_p1[$];
    preq_t q_p2[$];
    bw_t   q_br[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    p1_tog = 0, p2_tog = 0, br_cnt = 0;
    int    ack_dly = 3;
    bit    p1_freeze = 0, p2_freeze = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // SDRAM port models: echo req onto ack after ack_dly+1 cycles unless frozen.
    initial begin
        int c1;
        c1 = 0;
        port1_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                port1_ack = 1'b0; c1 = 0;
            end else if (port1_req !== port1_ack && !p1_freeze) begin
                if (c1 >= ack_dly) begin port1_ack = port1_req; c1 = 0; end
                else c1++;
            end
        end
    end

    initial begin
        int c2;
        c2 = 0;
        port2_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                port2_ack = 1'b0; c2 = 0;
            end else if (port2_req !== port2_ack && !p2_freeze) begin
                if (c2 >= ack_dly) begin port2_ack = port2_req; c2 = 0; end
                else c2++;
            end
        end
    end

    // Output monitors: every req toggle / dl_wr pulse consumes one scoreboard entry.
    initial begin
        logic p1_prev, p2_prev;
        preq_t e;
        bw_t b;
        p1_prev = 1'b0;
        p2_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                p1_prev = 1'b0;
                p2_prev = 1'b0;
            end else begin
                if (port1_req !== p1_prev) begin
                    p1_prev = port1_req;
                    p1_tog++;
                    chk("p1 req expected", 32'(q_p1.size() != 0), 1);
                    if (q_p1.size() != 0) begin
                        e = q_p1.pop_front();
                        chk("port1_a", 32'(port1_a), 32'(e.a));
                        chk("port1_ds", 32'(port1_ds), 32'(e.ds));
                        chk("port1_d", 32'(port1_d), 32'(e.d));
                    end
                end
                if (port2_req !== p2_prev) begin
                    p2_prev = port2_req;
                    p2_tog++;
                    chk("p2 req expected", 32'(q_p2.size() != 0), 1);
                    if (q_p2.size() != 0) begin
                        e = q_p2.pop_front();
                        chk("port2_a", 32'(port2_a), 32'(e.a));
                        chk("port2_ds", 32'(port2_ds), 32'(e.ds));
                        chk("port2_d", 32'(port2_d), 32'(e.d));
                    end
                end
                if (dl_wr === 1'b1) begin
                    br_cnt++;
                    chk("dl_wr expected", 32'(q_br.size() != 0), 1);
                    if (q_br.size() != 0) begin
                        b = q_br.pop_front();
                        chk("dl_addr", 32'(dl_addr), 32'(b.a));
                        chk("dl_data", 32'(dl_data), 32'(b.d));
                    end
                end
            end
        end
    end

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx, input bit honor);
        if (honor) begin
            for (int k = 0; k < 2000 && ioctl_wait; k++) @(negedge clk);
            chk("ioctl_wait released", 32'(ioctl_wait), 0);
        end
        @(negedge clk);
        ioctl_addr = a; ioctl_dout = d; ioctl_index = idx; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0; ioctl_index = 8'd0;
    endtask

    task automatic exp_p1(input logic [24:0] a, input logic [7:0] d);
        q_p1.push_back('{a: a[23:1], ds: (a[0] ? 2'b10 : 2'b01), d: {d, d}});
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 500; i++) begin
            if (q_p1.size() == 0 && q_p2.size() == 0 && q_br.size() == 0 &&
                port1_req === port1_ack && port2_req === port2_ack) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk(nm, 32'(q_p1.size() + q_p2.size() + q_br.size()), 0);
    endtask

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    vec_t vt[14];

    initial begin
        int t1, t2, tb0;
        vt[0]  = '{a:25'h00003, d:8'h5A, idx:8'h00, n1:1, n2:0, nb:0, pa:23'h000001, ds:2'b10};
        vt[1]  = '{a:25'h14001, d:8'h11, idx:8'h00, n1:0, n2:1, nb:0, pa:23'h000002, ds:2'b10};
        vt[2]  = '{a:25'h18000, d:8'h22, idx:8'h00, n1:0, n2:1, nb:0, pa:23'h000001, ds:2'b01};
        vt[3]  = '{a:25'h1C205, d:8'h3C, idx:8'h00, n1:0, n2:0, nb:1, pa:23'h000000, ds:2'b00};
        vt[4]  = '{a:25'h0A010, d:8'h77, idx:8'h00, n1:1, n2:0, nb:1, pa:23'h005008, ds:2'b01};
        vt[5]  = '{a:25'h30000, d:8'h99, idx:8'h00, n1:0, n2:0, nb:0, pa:23'h000000, ds:2'b00};
        vt[6]  = '{a:25'h0FFFF, d:8'hA5, idx:8'h00, n1:1, n2:0, nb:1, pa:23'h007FFF, ds:2'b10};
        vt[7]  = '{a:25'h1BFFF, d:8'hC3, idx:8'h00, n1:0, n2:1, nb:0, pa:23'h007FFF, ds:2'b01};
        vt[8]  = '{a:25'h09FFF, d:8'h0F, idx:8'h00, n1:1, n2:0, nb:0, pa:23'h004FFF, ds:2'b10};
        vt[9]  = '{a:25'h1C000, d:8'hE1, idx:8'h00, n1:0, n2:0, nb:1, pa:23'h000000, ds:2'b00};
        vt[10] = '{a:25'h10000, d:8'hB4, idx:8'h00, n1:0, n2:1, nb:0, pa:23'h000000, ds:2'b01};
        vt[11] = '{a:25'h1FFFF, d:8'h6E, idx:8'h00, n1:0, n2:0, nb:1, pa:23'h000000, ds:2'b00};
        vt[12] = '{a:25'h00010, d:8'h33, idx:8'h01, n1:0, n2:0, nb:0, pa:23'h000000, ds:2'b00};
        vt[13] = '{a:25'h20000, d:8'h44, idx:8'h00, n1:0, n2:0, nb:0, pa:23'h000000, ds:2'b00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst port1_req", 32'(port1_req), 0);
        chk("rst port2_req", 32'(port2_req), 0);
        chk("rst ioctl_wait", 32'(ioctl_wait), 0);
        chk("rst dl_wr", 32'(dl_wr), 0);
        chk("rst rom_loaded", 32'(rom_loaded), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst port1_a", 32'(port1_a), 0);
        chk("rst port2_d", 32'(port2_d), 0);
        chk("rst dl_addr", 32'(dl_addr), 0);
`ifdef ROM_LOADER_CHECKSUM_EN
        chk("rst checksum", 32'(checksum), 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        ioctl_download = 1'b1;
        @(negedge clk);

        // Routing table
        for (int i = 0; i < 14; i++) begin
            t1 = p1_tog; t2 = p2_tog; tb0 = br_cnt;
            if (vt[i].n1 != 0) q_p1.push_back('{a: vt[i].pa, ds: vt[i].ds, d: {vt[i].d, vt[i].d}});
            if (vt[i].n2 != 0) q_p2.push_back('{a: vt[i].pa, ds: vt[i].ds, d: {vt[i].d, vt[i].d}});
            if (vt[i].nb != 0) q_br.push_back('{a: vt[i].a[16:0], d: vt[i].d});
            wr_byte(vt[i].a, vt[i].d, vt[i].idx, 1'b1);
            wait_drain($sformatf("v%0d drained", i));
            chk($sformatf("v%0d p1 toggles", i), 32'(p1_tog - t1), 32'(vt[i].n1));
            chk($sformatf("v%0d p2 toggles", i), 32'(p2_tog - t2), 32'(vt[i].n2));
            chk($sformatf("v%0d dl_wr pulses", i), 32'(br_cnt - tb0), 32'(vt[i].nb));
        end

        // Backpressure: ack frozen, ioctl_wait rises at six queued bytes
        p1_freeze = 1;
        for (int i = 0; i < 10; i++) begin
            exp_p1(25'h00100 + 25'(i), 8'h40 + 8'(i));
            if (i < 6) begin
                wr_byte(25'h00100 + 25'(i), 8'h40 + 8'(i), 8'h00, 1'b0);
                if (i == 4) chk("wait low at count 5", 32'(ioctl_wait), 0);
                if (i == 5) begin
                    chk("wait high at count 6", 32'(ioctl_wait), 1);
                    repeat (40) @(negedge clk);
                    chk("wait held while frozen", 32'(ioctl_wait), 1);
                    p1_freeze = 0;
                end
            end else begin
                wr_byte(25'h00100 + 25'(i), 8'h40 + 8'(i), 8'h00, 1'b1);
            end
        end
        chk("bp overflow", 32'(overflow), 0);
        wait_drain("bp drained");

        // Overflow: nine bytes into a frozen port, ioctl_wait ignored
        p1_freeze = 1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_p1(25'h00200 + 25'(i), 8'h80 + 8'(i));
            wr_byte(25'h00200 + 25'(i), 8'h80 + 8'(i), 8'h00, 1'b0);
            if (i == 7) chk("no overflow at 8", 32'(overflow), 0);
        end
        chk("overflow set", 32'(overflow), 1);
        p1_freeze = 0;
        wait_drain("ovf drained");
        chk("overflow sticky", 32'(overflow), 1);
        ioctl_download = 1'b0;
        for (int k = 0; k < 200 && !rom_loaded; k++) @(negedge clk);
        chk("ovf rom_loaded", 32'(rom_loaded), 1);
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk);
        chk("overflow cleared", 32'(overflow), 0);
        chk("rom_loaded cleared", 32'(rom_loaded), 0);

        // Completion: bytes 0x01..0x10, then end the download mid-drain
        for (int i = 1; i <= 16; i++) begin
            exp_p1(25'h00300 + 25'(i), 8'(i));
            wr_byte(25'h00300 + 25'(i), 8'(i), 8'h00, 1'b1);
        end
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        chk("loaded waits for drain", 32'(rom_loaded), 0);
        chk("wait during drain", 32'(ioctl_wait), 1);
        for (int k = 0; k < 1000 && !rom_loaded; k++) @(negedge clk);
        chk("rom_loaded set", 32'(rom_loaded), 1);
        chk("all acked at load", 32'(q_p1.size() + ((port1_req !== port1_ack) ? 1 : 0)), 0);
        chk("wait low after load", 32'(ioctl_wait), 0);
`ifdef ROM_LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'h0088);
`endif
        repeat (20) @(negedge clk);
        chk("rom_loaded stable", 32'(rom_loaded), 1);

        // Reset while waiting for a port1 ack
        ioctl_download = 1'b1;
        @(negedge clk);
        p1_freeze = 1;
        exp_p1(25'h00ABC, 8'h5C);
        wr_byte(25'h00ABC, 8'h5C, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("port1 busy in WAIT", 32'(port1_req !== port1_ack), 1);
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("mid rst port1_req", 32'(port1_req), 0);
        chk("mid rst port1_a", 32'(port1_a), 0);
        chk("mid rst port1_ds", 32'(port1_ds), 0);
        chk("mid rst port1_d", 32'(port1_d), 0);
        chk("mid rst dl_wr", 32'(dl_wr), 0);
        chk("mid rst ioctl_wait", 32'(ioctl_wait), 0);
        chk("mid rst rom_loaded", 32'(rom_loaded), 0);
        p1_freeze = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post rst port1_req", 32'(port1_req), 0);
        wait_drain("post rst quiet");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Buffered ROM download router between the HPS ioctl byte stream and the game's memories. It sits upstream of the SDRAM controller and the core's internal BRAMs. Each downloaded byte is captured, queued in a small FIFO, classified by address, and delivered to one of three destinations: port1 (CPU ROMs), port2 (sprite ROMs merged into 32-bit words), or the BRAM write strobe (tiles, palettes, LUT). It also throttles the HPS and reports when the load is complete.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `clk` in 1: system clock (clk_72 domain).
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download window active.
- `ioctl_wr` in 1: byte strobe; level, edge-detected.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: only index 0 is accepted.
- `ioctl_wait` out 1: throttle request to the HPS.
- `port1_req` out 1: toggle handshake to SDRAM port1.
- `port1_ack` in 1: SDRAM port1 ack toggle.
- `port1_a` out 23: port1 word address.
- `port1_ds` out 2: port1 byte enables.
- `port1_d` out 16: port1 write data (byte duplicated).
- `port2_req`, `port2_ack`, `port2_a`, `port2_ds`, `port2_d`: same as port1, for port2.
- `dl_wr` out 1: one-cycle BRAM write pulse.
- `dl_addr` out 17: BRAM byte address.
- `dl_data` out 8: BRAM data.
- `rom_loaded` out 1: load complete.
- `overflow` out 1: sticky; a byte was pushed while the FIFO was full.
- `checksum` out 16: present only with `ROM_LOADER_CHECKSUM_EN`.

## Operation
- Capture: a rising edge of `ioctl_wr` while `ioctl_download`=1 and `ioctl_index`=0 pushes {addr, data}.
  - Bytes that do not meet this condition are ignored.
- Routing, taken at FIFO head by addr A:
  - A < 0x10000 → port1. `port1_a`=A[23:1]; `port1_ds`={A[0],~A[0]}; `port1_d`={d,d}.
  - 0x10000 ≤ A < 0x1C000 → port2. Let O = A−0x10000.
    - `port2_a`={O[23:16],O[13:0],O[15]}.
    - `port2_ds`={O[14],~O[14]}.
    - `port2_d`={d,d}.
  - A ≥ 0x1C000 and A < 0x20000 → BRAM only.
  - 0x0A000 ≤ A < 0x10000 → port1 **and** BRAM. This is one entry with two deliveries; the entry pops only after both are done.
  - A ≥ 0x20000 → popped and discarded.
- Handshake, per port:
  - The port is idle when req==ack.
  - Issue = drive a/ds/d, then toggle req in the same cycle.
  - a/ds/d are held stable until ack==req.
  - Only one request is outstanding per port.
  - The head stalls while its target port is busy. There is no reordering.
- BRAM delivery: `dl_wr`=1 for exactly one cycle, with `dl_addr`=A[16:0] and `dl_data`=d. It never stalls.
- Dispatch state machine:
  - IDLE: wait for a non-empty FIFO.
  - ISSUE: deliver to the target(s).
  - WAIT: wait until every SDRAM target has ack==req.
  - Then POP and return to IDLE.
  - Dual-target entries: BRAM is written in ISSUE, then port1 completes in WAIT.
- Completion:
  - A rising edge of `ioctl_download` clears `rom_loaded`, `overflow` and the checksum.
  - After a falling edge of `ioctl_download`, `rom_loaded` sets once the FIFO is empty and both ports are idle.
- `ioctl_wait` = (count ≥ DEPTH−2) or (`ioctl_download` falling edge pending and not yet loaded).

## Timing
- Reset values (async on `reset_n`=0):
  - All req=0, `ioctl_wait`=0, `dl_wr`=0, `rom_loaded`=0, `overflow`=0.
  - a/ds/d/`dl_addr`/`dl_data`=0, checksum=0.
  - FIFO is empty.
  - All are released synchronously on the next edge.
- Latency:
  - Push happens 1 cycle after the `ioctl_wr` rise.
  - Head delivery (req toggle or `dl_wr`) happens 1 cycle after push into an empty FIFO.
  - Minimum BRAM-only throughput: 1 byte per 2 cycles.
- Simultaneous push and pop: allowed, and the count is unchanged.
- Push when full:
  - Push while count=DEPTH and no pop in the same cycle: the byte is dropped and `overflow`=1.
  - Push while count=DEPTH with a pop in the same cycle: accepted.
- Reset mid-request: req returns to 0. The SDRAM controller must be reset in the same cycle so that ack is also 0.
- `ioctl_download` falling while the FIFO is non-empty: draining continues, and `rom_loaded` waits for it.
- `rom_loaded` is stable while `ioctl_download`=0.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined:
  - `checksum` = 16-bit wrapping sum of every accepted byte, added at push time.
  - It is cleared at download start.
  - The port exists.
- `ROM_LOADER_CHECKSUM_EN` undefined: the port and adder are absent, and behaviour is otherwise identical.

## Test plan
- Byte 0x5A at A=0x00003 with ack echoed after 4 cycles → `port1_a`=0x000001, ds=2'b10, d=0x5A5A, one req toggle.
- A=0x14001 → `port2_a`={8'h0,14'h0001,1'b0}, ds=2'b10. A=0x18000 → `port2_a` LSB=1.
- A=0x1C205 data 0x3C → single `dl_wr` pulse, `dl_addr`=0x1C205, no port toggles. A=0x0A010 → `dl_wr` plus a port1 request, one pop.
- Hold port1 ack for 50 cycles while streaming 10 port1 bytes → `ioctl_wait` high at count 6 (DEPTH=8), no overflow, order preserved.
- Ignore `ioctl_wait` and push 9 bytes with ack frozen → `overflow`=1. A new download start clears it.
- Download bytes 0x01..0x10 then drop `ioctl_download` → `rom_loaded` rises after the last ack. With `ROM_LOADER_CHECKSUM_EN`, `checksum`=0x0088. Pulling `reset_n` low mid-WAIT zeroes all outputs immediately.
